// File: rtl/new_means_calculation_block.sv
// New-means datapath: divides each centroid's 7 accumulated coordinates by its point count.
// Optional macro ROUND_NEAREST_EN selects round-half-up; otherwise the mean is truncated.
module new_means_calculation_block #(
    parameter int dataWidth        = 91,
    parameter int accum_width      = 154,
    parameter int accum_cord_width = 22,
    parameter int cordinate_width  = 13,
    parameter int count_width      = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   means_start,
    input  logic                   means_clr,
    output logic [2:0]             accum_sel,
    input  logic [accum_width-1:0] accum_in,
    input  logic [count_width-1:0] count_in,
    output logic [dataWidth-1:0]   new_centroid_in,
    output logic [2:0]             cent_num,
    output logic                   divide_by_0,
    output logic                   convergence_reg_en,
    output logic                   means_busy,
    output logic                   means_done
);

    localparam int NCORD = 7;
`ifdef ROUND_NEAREST_EN
    localparam int DVD_W = accum_cord_width + 1;
`else
    localparam int DVD_W = accum_cord_width;
`endif
    localparam int CNT_W = $clog2(DVD_W + 1);
    localparam logic [cordinate_width-1:0] SAT = '1;

    typedef enum logic [2:0] {IDLE, LOAD, DIV, OUT, DONE} state_t;

    state_t                 state;
    logic [2:0]             idx;
    logic [CNT_W-1:0]       div_cnt;
    logic [count_width-1:0] divisor;

    // Each lane shifts its dividend out at the top while quotient bits enter at the bottom,
    // so after DVD_W steps the dividend register holds the quotient.
    logic [DVD_W-1:0]       dvd      [NCORD];
    logic [count_width-1:0] rem      [NCORD];
    logic [DVD_W-1:0]       dvd_nxt  [NCORD];
    logic [count_width-1:0] rem_nxt  [NCORD];
    logic [DVD_W-1:0]       load_dvd [NCORD];
    logic [dataWidth-1:0]   quot_sat;

    always_comb begin : div_step
        logic [count_width:0] trial;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        trial    = '0;
        quot_sat = '0;
        for (int i = 0; i < NCORD; i++) begin
            dvd_nxt[i] = dvd[i];
            rem_nxt[i] = rem[i];
            trial = {rem[i], dvd[i][DVD_W-1]};
            if (trial >= {1'b0, divisor}) begin
                // Partial remainder is always below the divisor, so it fits count_width bits.
                rem_nxt[i] = trial[count_width-1:0] - divisor;
                dvd_nxt[i] = {dvd[i][DVD_W-2:0], 1'b1};
            end else begin
                rem_nxt[i] = trial[count_width-1:0];
                dvd_nxt[i] = {dvd[i][DVD_W-2:0], 1'b0};
            end
            quot_sat[i*cordinate_width +: cordinate_width] =
                (|dvd_nxt[i][DVD_W-1:cordinate_width]) ? SAT : dvd_nxt[i][cordinate_width-1:0];
        end
    end

    always_comb begin
        for (int i = 0; i < NCORD; i++) begin
`ifdef ROUND_NEAREST_EN
            load_dvd[i] = DVD_W'(accum_in[i*accum_cord_width +: accum_cord_width])
                        + DVD_W'(count_in >> 1);
`else
            load_dvd[i] = accum_in[i*accum_cord_width +: accum_cord_width];
`endif
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            idx                <= '0;
            div_cnt            <= '0;
            divisor            <= '0;
            accum_sel          <= '0;
            new_centroid_in    <= '0;
            cent_num           <= '0;
            divide_by_0        <= 1'b0;
            convergence_reg_en <= 1'b0;
            means_busy         <= 1'b0;
            means_done         <= 1'b0;
            // NOTE: the divider arrays are small register banks, not RAM, so they are reset.
            for (int i = 0; i < NCORD; i++) begin
                dvd[i] <= '0;
                rem[i] <= '0;
            end
        end else begin
            convergence_reg_en <= 1'b0;
            means_done         <= 1'b0;
            if (means_clr) begin
                state      <= IDLE;
                means_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (means_start) begin
                            state      <= LOAD;
                            idx        <= '0;
                            accum_sel  <= '0;
                            means_busy <= 1'b1;
                        end
                    end
                    LOAD: begin
                        divisor <= count_in;
                        div_cnt <= '0;
                        for (int i = 0; i < NCORD; i++) begin
                            dvd[i] <= load_dvd[i];
                            rem[i] <= '0;
                        end
                        if (count_in == '0) begin
                            // Zero count: flag it and let the consumer keep the old centroid.
                            state              <= OUT;
                            new_centroid_in    <= '0;
                            divide_by_0        <= 1'b1;
                            cent_num           <= idx;
                            convergence_reg_en <= 1'b1;
                        end else begin
                            state <= DIV;
                        end
                    end
                    DIV: begin
                        div_cnt <= div_cnt + 1'b1;
                        for (int i = 0; i < NCORD; i++) begin
                            dvd[i] <= dvd_nxt[i];
                            rem[i] <= rem_nxt[i];
                        end
                        if (div_cnt == CNT_W'(DVD_W - 1)) begin
                            state              <= OUT;
                            new_centroid_in    <= quot_sat;
                            divide_by_0        <= 1'b0;
                            cent_num           <= idx;
                            convergence_reg_en <= 1'b1;
                        end
                    end
                    OUT: begin
                        if (idx == 3'd7) begin
                            state      <= DONE;
                            means_done <= 1'b1;
                        end else begin
                            state     <= LOAD;
                            idx       <= idx + 3'd1;
                            accum_sel <= idx + 3'd1;
                        end
                    end
                    DONE: begin
                        state      <= IDLE;
                        means_busy <= 1'b0;
                    end
                    default: begin
                        state      <= IDLE;
                        means_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/new_means_calculation_block.md
NEW_MEANS_CALCULATION_BLOCK -- requirements
Module: new_means_calculation_block

Interface
REQ-001 The block SHALL have parameter dataWidth, default 91, meaning the packed centroid width (7 coordinates).
REQ-002 The block SHALL have parameter accum_width, default 154, meaning the packed accumulator width (7 x 22).
REQ-003 The block SHALL have parameter accum_cord_width, default 22, meaning the width of one accumulated coordinate.
REQ-004 The block SHALL have parameter cordinate_width, default 13, meaning the width of one output coordinate, unsigned.
REQ-005 The block SHALL have parameter count_width, default 10, meaning the width of the per-centroid point count.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 The block SHALL have port means_start, input, 1 bit: controller pulse that starts a pass over 8 centroids.
REQ-009 The block SHALL have port means_clr, input, 1 bit: synchronous abort to IDLE.
REQ-010 The block SHALL have port accum_sel, output, 3 bits: index of the accumulator and count being requested.
REQ-011 The block SHALL have port accum_in, input, accum_width bits: selected accumulator, with coordinate i at bits [22i+21:22i].
REQ-012 The block SHALL have port count_in, input, count_width bits: point count of the selected centroid.
REQ-013 The block SHALL have port new_centroid_in, output, dataWidth bits: the mean, with coordinate i at bits [13i+12:13i].
REQ-014 The block SHALL have port cent_num, output, 3 bits: index of the centroid on new_centroid_in.
REQ-015 The block SHALL have port divide_by_0, output, 1 bit: the current centroid had count 0.
REQ-016 The block SHALL have port convergence_reg_en, output, 1 bit: one-cycle strobe marking valid output data.
REQ-017 The block SHALL have port means_busy, output, 1 bit: high whenever the block is not in IDLE.
REQ-018 The block SHALL have port means_done, output, 1 bit: one-cycle pulse when the pass completes.

Function
REQ-019 The block SHALL implement FSM states IDLE, LOAD, DIV, OUT and DONE.
REQ-020 IDLE SHALL go to LOAD with index 0 on means_start; means_start SHALL be ignored in every other state.
REQ-021 LOAD (1 cycle) SHALL latch accum_in and count_in, with accum_sel = index.
REQ-022 On leaving LOAD, the FSM SHALL go to OUT if the latched count is 0, else to DIV.
REQ-023 DIV SHALL run 22 cycles: 7 parallel restoring dividers sharing the divisor, producing one quotient bit per cycle, MSB first.
REQ-024 A quotient greater than 8191 SHALL saturate to 13'h1FFF; otherwise the low 13 bits SHALL be output.
REQ-025 OUT (1 cycle) SHALL assert convergence_reg_en.
REQ-026 On leaving OUT, the FSM SHALL go to LOAD with index+1 if index < 7, else to DONE.
REQ-027 DONE (1 cycle) SHALL pulse means_done and then go to IDLE.
REQ-028 When count is 0, new_centroid_in SHALL be 0 and divide_by_0 = 1 in OUT, so the downstream block substitutes the old centroid.
REQ-029 new_centroid_in, cent_num and divide_by_0 SHALL be registered, updated only on entry to OUT, and held until the next OUT.
REQ-030 Latency SHALL be 24 cycles per nonzero-count centroid and 2 cycles per zero-count centroid.
REQ-031 means_clr SHALL take precedence over means_start and every other transition: next state IDLE, no strobe, no means_done; output data SHALL hold.

Reset
REQ-032 On rst_n low, the block SHALL asynchronously enter IDLE.
REQ-033 On rst_n low, new_centroid_in, cent_num, divide_by_0, convergence_reg_en, means_busy, means_done and accum_sel SHALL all be 0.
REQ-034 On rst_n low, the divider registers SHALL clear.
REQ-035 A reset during DIV SHALL discard the partial result, and no strobe SHALL follow.

Configuration
REQ-036 The macro ROUND_NEAREST_EN SHALL select the rounding mode.
REQ-037 With ROUND_NEAREST_EN defined, LOAD SHALL add floor(count/2) to each 22-bit dividend, widened to 23 bits, giving round-half-up; the division SHALL take 23 cycles and the latency SHALL become 25.
REQ-038 Without ROUND_NEAREST_EN, the mean SHALL be truncated and DIV SHALL be 22 cycles.

Verification
REQ-039 A bench SHALL cover: all coordinates 300, count 3 -> all coordinates 100, strobe 24 cycles after means_start, cent_num 0.
REQ-040 A bench SHALL cover: coordinate 302, count 3 -> 100 without ROUND_NEAREST_EN, 101 with it.
REQ-041 A bench SHALL cover: count 0 at centroid 2 -> divide_by_0 = 1, data 0, strobe 2 cycles after that centroid's LOAD.
REQ-042 A bench SHALL cover: coordinate 22'h3FFFFF, count 1 -> 13'h1FFF.
REQ-043 A bench SHALL cover: 8 centroids with count 5 -> 8 strobes with cent_num 0..7, means_done in cycle 193, means_busy low afterwards.
REQ-044 A bench SHALL cover: means_clr at DIV cycle 10, then rst_n low mid-DIV -> IDLE, no strobe, outputs 0 after reset.
